hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage core. It sits beside the forwarding logic and covers the dependencies forwarding cannot resolve. It stalls IF/ID and injects bubbles into ID/EX for dependencies that need more than the existing MEM/WB→EX and EX/MEM→ID-branch forward paths. It also flushes IF/ID on taken branches and freezes the whole pipe while data memory is busy.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `IF_ID_Rs1`, `IF_ID_Rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads that source.
- `id_is_branch`  in  1  ID instruction is a conditional branch; it is resolved in ID.
- `branch_taken`  in  1  ID branch/jump redirects the PC this cycle.
- `ID_EX_Rd`  in  5  destination register of the instruction in EX.
- `ID_EX_regwrite`, `ID_EX_memread`  in  1 each  EX instruction writes Rd / is a load.
- `EX_MEM_Rd`  in  5  destination register of the instruction in MEM.
- `EX_MEM_regwrite`, `EX_MEM_memread`  in  1 each  MEM instruction writes Rd / is a load.
- `mem_busy`  in  1  data memory is not ready; the pipe must hold.
- `pc_write`  out  1  PC register update enable.
- `IF_ID_write`  out  1  IF/ID register load enable.
- `IF_ID_flush`  out  1  zero IF/ID at the next edge.
- `ID_EX_bubble`  out  1  load a NOP into ID/EX at the next edge.
- `pipe_freeze`  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- `stall_count`  out  `CNT_W`  saturating count of hazard-stall cycles.

## Operation
Match terms:
- `mEX` = `ID_EX_regwrite` && `ID_EX_Rd` != 0 && ((`id_uses_rs1` && `ID_EX_Rd` == `IF_ID_Rs1`) || (`id_uses_rs2` && `ID_EX_Rd` == `IF_ID_Rs2`)).
- `mMEM` is the same test against the `EX_MEM_*` signals.

Stall requirement `need` (0..2), evaluated in RUN:
- Non-branch consumer: `mEX` gives 1; otherwise 0. The MEM/WB→EX forward covers distance 2.
- Branch consumer: `mEX` && `ID_EX_memread` gives 2; `mEX` otherwise gives 1; `mMEM` && `EX_MEM_memread` gives 1; otherwise 0.

FSM states:
- RUN: if `need` > 0, assert the stall outputs this cycle. If `need` == 2, go to STALL with `cnt` = 1. If `need` == 1, stay in RUN.
- STALL: assert the stall outputs without re-evaluating `need`. Decrement `cnt`; return to RUN when `cnt` reaches 0.

Output values:
- Stall outputs: `pc_write` = 0, `IF_ID_write` = 0, `ID_EX_bubble` = 1, `IF_ID_flush` = 0.
- Normal (RUN, `need` = 0): `pc_write` = 1, `IF_ID_write` = 1, `ID_EX_bubble` = 0. `IF_ID_flush` = `branch_taken`.

Event rules:
- `branch_taken` is ignored in any stall cycle; the branch operands are not yet valid.
- `mem_busy` overrides everything: `pipe_freeze` = 1, `pc_write` = 0, `IF_ID_write` = 0, `ID_EX_bubble` = 0, `IF_ID_flush` = 0. State, `cnt` and `stall_count` hold. On release, the FSM resumes exactly where it stopped.
- `stall_count` increments by 1 on every non-frozen cycle where `ID_EX_bubble` = 1. It saturates at all-ones.

## Timing
- Reset (async assert, any state, including mid-STALL) forces: state RUN, `cnt` 0, `stall_count` 0.
- Outputs during reset: `pc_write` = 1, `IF_ID_write` = 1, `IF_ID_flush` = 0, `ID_EX_bubble` = 0, `pipe_freeze` = 0.
- Detection-to-output path is combinational, so a stall takes effect in the same cycle it is detected. State, `cnt` and `stall_count` update on the rising `clk` edge.
- Stall lengths: ALU-to-ALU at distance 1 = 1 cycle; ALU-to-branch at distance 1 = 1 cycle; load-to-branch at distance 1 = 2 consecutive cycles; load-to-branch at distance 2 = 1 cycle.
- `mem_busy` rising in STALL with `cnt` = 1: freeze cycles follow, then exactly one more stall cycle.
- Rd = x0 never causes a stall.

## Structure
- Shared package `hazard_pkg`: state enum {RUN, STALL}, constant `REG_ZERO` = 5'd0, the `need` encoding.
- One combinational sub-module, `dep_match`, computes one register-match term. It is instantiated twice, once for EX and once for MEM.
- The FSM, counter and output decode live in the top level.

## Test plan
- `add x5` in EX, ID `sub` reads x5 → one cycle with `ID_EX_bubble` = 1 and `pc_write` = 0; `stall_count` = 1.
- `lw x6` in EX, ID `beq x6,x0` → two stall cycles, then RUN; `stall_count` += 2. `branch_taken` = 1 during the stall cycles produces no flush.
- `lw x7` in MEM, ID `bne x7` → 1 stall. The same pattern with a non-branch consumer → 0 stalls.
- Producer with Rd = x0 and `regwrite` = 1 matching the consumer → no stall; `pc_write` stays 1.
- STALL entered (`cnt` = 1), `mem_busy` held 3 cycles → `pipe_freeze` = 1 for 3 cycles, `stall_count` unchanged, then 1 stall cycle, then RUN.
- `rst_n` asserted mid-STALL → outputs return to reset values immediately; `stall_count` = 0; first cycle after release is RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_ONE  = 2'd1,
        NEED_TWO  = 2'd2
    } need_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dep_match.sv
// Detects whether a producer stage writes a register the ID instruction reads.
module dep_match
    import hazard_pkg::*;
(
    input  logic [4:0] rd,
    input  logic       regwrite,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    output logic       match
);

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign match = regwrite && (rd != REG_ZERO) &&
                   ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble/flush/freeze control for hazards the forwarding paths cannot cover.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_Rd,
    input  logic             EX_MEM_regwrite,
    input  logic             EX_MEM_memread,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_count
);

    state_t     state, next_state;
    logic [1:0] cnt, next_cnt;
    need_t      need;
    logic       m_ex, m_mem;
    logic       stall_cycle;

    dep_match u_match_ex (
        .rd       (ID_EX_Rd),
        .regwrite (ID_EX_regwrite),
        .rs1      (IF_ID_Rs1),
        .rs2      (IF_ID_Rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .match    (m_ex)
    );

    dep_match u_match_mem (
        .rd       (EX_MEM_Rd),
        .regwrite (EX_MEM_regwrite),
        .rs1      (IF_ID_Rs1),
        .rs2      (IF_ID_Rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .match    (m_mem)
    );

    // Branches resolve in ID, so they need operands one stage earlier than ALU ops.
    always_comb begin
        need = NEED_NONE;
        if (id_is_branch) begin
            if (m_ex && ID_EX_memread)
                need = NEED_TWO;
            else if (m_ex)
                need = NEED_ONE;
            else if (m_mem && EX_MEM_memread)
                need = NEED_ONE;
        end else if (m_ex) begin
            need = NEED_ONE;
        end
    end

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        stall_cycle = 1'b0;
        case (state)
            RUN: begin
                if (need != NEED_NONE)
                    stall_cycle = 1'b1;
                if (need == NEED_TWO) begin
                    next_state = STALL;
                    next_cnt   = 2'd1;
                end
            end
            STALL: begin
                stall_cycle = 1'b1;
                next_cnt    = cnt - 2'd1;
                if (cnt <= 2'd1)
                    next_state = RUN;
            end
            default: next_state = RUN;
        endcase
        if (mem_busy) begin
            next_state = state;
            next_cnt   = cnt;
        end
    end

    // Reset gating keeps the pipe running normally while rst_n is low.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                IF_ID_write = 1'b0;
            end else if (stall_cycle) begin
                pc_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end else begin
                IF_ID_flush = branch_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= 2'd0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (!mem_busy && stall_cycle && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: directed vectors push expected outputs, a monitor pops and compares.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  IF_ID_Rs1 = '0, IF_ID_Rs2 = '0;
    logic        id_uses_rs1 = 0, id_uses_rs2 = 0, id_is_branch = 0, branch_taken = 0;
    logic [4:0]  ID_EX_Rd = '0, EX_MEM_Rd = '0;
    logic        ID_EX_regwrite = 0, ID_EX_memread = 0;
    logic        EX_MEM_regwrite = 0, EX_MEM_memread = 0;
    logic        mem_busy = 0;
    logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze;
    logic [31:0] stall_count;

    typedef struct {
        string       nm;
        logic [4:0]  outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checkCount = 0;
    int   passCount  = 0;

    localparam logic [4:0] RUNO = 5'b11000;
    localparam logic [4:0] FLSH = 5'b11100;
    localparam logic [4:0] STLO = 5'b00010;
    localparam logic [4:0] FRZO = 5'b00001;

    hazard_stall_ctrl #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_Rs1       (IF_ID_Rs1),
        .IF_ID_Rs2       (IF_ID_Rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_is_branch    (id_is_branch),
        .branch_taken    (branch_taken),
        .ID_EX_Rd        (ID_EX_Rd),
        .ID_EX_regwrite  (ID_EX_regwrite),
        .ID_EX_memread   (ID_EX_memread),
        .EX_MEM_Rd       (EX_MEM_Rd),
        .EX_MEM_regwrite (EX_MEM_regwrite),
        .EX_MEM_memread  (EX_MEM_memread),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_bubble    (ID_EX_bubble),
        .pipe_freeze     (pipe_freeze),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge and queues the expected response.
    task automatic applyStimulus(input string nm, input logic rst,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic br, input logic tk,
                                 input logic [4:0] exRd, input logic exRw, input logic exMr,
                                 input logic [4:0] memRd, input logic memRw, input logic memMr,
                                 input logic busy,
                                 input logic [4:0] expOuts, input logic [31:0] expCnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_is_branch = br; branch_taken = tk;
        ID_EX_Rd = exRd; ID_EX_regwrite = exRw; ID_EX_memread = exMr;
        EX_MEM_Rd = memRd; EX_MEM_regwrite = memRw; EX_MEM_memread = memMr;
        mem_busy = busy;
        e.nm = nm;
        e.outs = expOuts;
        e.cnt = expCnt;
        exp_q.push_back(e);
    endtask

    // Compares the presented outputs ({pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze}).
    task automatic checkOutput(input exp_t e);
        logic [4:0] act;
        act = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze};
        checkCount++;
        if (act === e.outs) passCount++;
        else $display("[TB] FAIL %s.outs actual %b required %b", e.nm, act, e.outs);
        checkCount++;
        if (stall_count === e.cnt) passCount++;
        else $display("[TB] FAIL %s.stall_count actual %0d required %0d", e.nm, stall_count, e.cnt);
    endtask

    // Monitor: one output sample per cycle, taken on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //            name          rst rs1 rs2 u1 u2 br tk exRd rw mr memRd rw mr busy exp  cnt
        applyStimulus("in_reset",    0, 5,  0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1, RUNO, 0);
        applyStimulus("idle",        1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 0);
        applyStimulus("alu_alu",     1, 5,  3, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, STLO, 0);
        applyStimulus("after_alu",   1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 1);
        applyStimulus("ld_br_1",     1, 6,  0, 1, 1, 1, 1, 6, 1, 1, 0, 0, 0, 0, STLO, 1);
        applyStimulus("ld_br_2",     1, 6,  0, 1, 1, 1, 1, 0, 0, 0, 6, 1, 1, 0, STLO, 2);
        applyStimulus("br_flush",    1, 6,  0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, FLSH, 3);
        applyStimulus("idle2",       1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 3);
        applyStimulus("ld_mem_br",   1, 7,  0, 1, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, STLO, 3);
        applyStimulus("after_mbr",   1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 4);
        applyStimulus("ld_mem_alu",  1, 7,  0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, RUNO, 4);
        applyStimulus("x0_ex",       1, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, RUNO, 4);
        applyStimulus("x0_mem_br",   1, 0,  0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, RUNO, 4);
        applyStimulus("alu_br",      1, 1,  9, 1, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, STLO, 4);
        applyStimulus("unused_src",  1, 9,  0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, RUNO, 5);
        applyStimulus("frz_enter",   1, 6,  0, 1, 1, 1, 0, 6, 1, 1, 0, 0, 0, 0, STLO, 5);
        for (int i = 0; i < 3; i++)
            applyStimulus("frz_hold",  1, 6,  0, 1, 1, 1, 1, 0, 0, 0, 6, 1, 1, 1, FRZO, 6);
        applyStimulus("frz_resume",  1, 6,  0, 1, 1, 1, 1, 0, 0, 0, 6, 1, 1, 0, STLO, 6);
        applyStimulus("frz_done",    1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 7);
        applyStimulus("frz_in_run",  1, 5,  0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, FRZO, 7);
        applyStimulus("run_resume",  1, 5,  0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, STLO, 7);
        applyStimulus("rst_enter",   1, 6,  0, 1, 1, 1, 0, 6, 1, 1, 0, 0, 0, 0, STLO, 8);
        applyStimulus("rst_midstl",  0, 6,  0, 1, 1, 1, 1, 0, 0, 0, 6, 1, 1, 0, RUNO, 0);
        applyStimulus("rst_release", 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 0);
        applyStimulus("post_rst",    1, 5,  0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, STLO, 0);
        applyStimulus("post_rst2",   1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
